pm1_bist_driver: RTL and testbench

PM1_BIST_DRIVER -- requirements
Module: pm1_bist_driver

---
 rtl/pm1_bist_pkg.sv | 33 +++
 rtl/pm1_bist_lfsr.sv | 36 +++
 rtl/pm1_bist_driver.sv | 105 ++++++++++
 tb/tb_pm1_bist_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pm1_bist_pkg.sv
// Shared types and constants for the pm1 BIST driver: FSM states, the
// x^16+x^14+x^13+x^11+1 tap mask, and the pad-to-bit maps of the pm1 netlist.
package pm1_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] POLY_TAPS = 16'hB400;

  // Bit positions of the pm1 input pads within pat_o.
  typedef enum int unsigned {
    PAD_A = 0, PAD_B, PAD_C, PAD_D, PAD_E, PAD_G, PAD_H, PAD_I,
    PAD_J, PAD_K, PAD_L, PAD_M, PAD_N, PAD_O, PAD_P, PAD_Q
  } pat_pad_e;

  // Bit positions of the pm1 output pads within resp_i.
  typedef enum int unsigned {
    PAD_R = 0, PAD_S, PAD_T, PAD_U, PAD_V, PAD_W, PAD_X,
    PAD_Y, PAD_Z, PAD_A0, PAD_B0, PAD_C0, PAD_D0
  } resp_pad_e;

  localparam int unsigned PAT_W  = PAD_Q + 1;
  localparam int unsigned RESP_W = PAD_D0 + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & POLY_TAPS)};
  endfunction

endpackage

// File: rtl/pm1_bist_lfsr.sv
// 16-bit Fibonacci shift register with synchronous load and a parallel XOR
// input; used as the pattern generator (XOR tied off) and as the MISR.
module pm1_bist_lfsr
  import pm1_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        en_i,
  input  logic [15:0] xor_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (en_i) begin
      state_d = lfsr_step(state_q) ^ xor_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/pm1_bist_driver.sv
// BIST driver for the combinational pm1 netlist: applies NUM_PATTERNS LFSR
// vectors, compacts the responses in a MISR and compares against GOLDEN_SIG.
module pm1_bist_driver
  import pm1_bist_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 256,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PAT_W-1:0]  pat_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature,
  output logic [15:0]       pat_count
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LAST_CNT = 16'(NUM_PATTERNS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        launch;
  logic        stepping;
  logic [15:0] misr_q;
  logic [15:0] misr_in;
  logic [15:0] misr_next;

  assign launch    = (state_q != ST_RUN) && start;
  assign stepping  = (state_q == ST_RUN);
  assign misr_in   = {{(16 - RESP_W){1'b0}}, resp_i};
  assign misr_next = lfsr_step(misr_q) ^ misr_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 16'd1;
        // Verdict is taken from the signature the final capture produces.
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          pass_d  = (misr_next == GOLDEN_SIG);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  pm1_bist_lfsr u_pat_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (launch),
    .load_val_i (SEED_EFF),
    .en_i       (stepping),
    .xor_i      ('0),
    .state_o    (pat_o)
  );

  pm1_bist_lfsr u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (launch),
    .load_val_i ('0),
    .en_i       (stepping),
    .xor_i      (misr_in),
    .state_o    (misr_q)
  );

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = misr_q;
  assign pat_count = cnt_q;

endmodule

// File: tb/tb_pm1_bist_driver.sv
// Bench for pm1_bist_driver: several parameterisations run side by side against
// a per-instance behavioural model, with a stand-in combinational pm1 netlist.
module tb_pm1_bist_driver;

  localparam int NI = 6;

  function automatic logic [15:0] poly_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [12:0] netlist(input logic [15:0] p);
    logic [12:0] r;
    for (int i = 0; i < 13; i++) r[i] = p[i] ^ (p[i+1] & p[i+3]);
    return r;
  endfunction

  function automatic logic [15:0] golden(input int unsigned n, input logic [15:0] seed);
    logic [15:0] l, m;
    l = seed;
    m = '0;
    for (int unsigned k = 0; k < n; k++) begin
      m = poly_step(m) ^ {3'b000, netlist(l)};
      l = poly_step(l);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD64 = golden(64, 16'hACE1);

  localparam int unsigned NUMS  [NI] = '{256, 1, 2, 2, 64, 5};
  localparam logic [15:0] SEEDS [NI] = '{16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1, 16'h0000};
  localparam logic [15:0] GOLDS [NI] = '{16'h0000, 16'h0000, 16'h0000, 16'h0003, GOLD64, 16'h0000};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] start_v;
  logic [15:0]   pat    [NI];
  logic [12:0]   resp   [NI];
  logic [NI-1:0] busy_v, done_v, pass_v;
  logic [15:0]   sig    [NI];
  logic [15:0]   cnt    [NI];

  logic [1:0]    mode   [NI];
  logic [12:0]   rnd    [NI];
  logic [12:0]   flip   [NI];

  logic [NI-1:0] m_run, m_fin, m_pass;
  logic [15:0]   m_lfsr [NI];
  logic [15:0]   m_misr [NI];
  int unsigned   m_cnt  [NI];

  int  n_vec = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pm1_bist_driver #(
      .NUM_PATTERNS (NUMS[g]),
      .LFSR_SEED    (SEEDS[g]),
      .GOLDEN_SIG   (GOLDS[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_v[g]),
      .pat_o     (pat[g]),
      .resp_i    (resp[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .pass      (pass_v[g]),
      .signature (sig[g]),
      .pat_count (cnt[g])
    );
  end

  // Response sources: zero, constant 1, random per cycle, or netlist with fault mask.
  always_comb begin
    for (int g = 0; g < NI; g++) begin
      resp[g] = '0;
      case (mode[g])
        2'd0:    resp[g] = '0;
        2'd1:    resp[g] = 13'h0001;
        2'd2:    resp[g] = rnd[g];
        default: resp[g] = netlist(pat[g]) ^ flip[g];
      endcase
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) rnd[g] <= 13'($urandom);
  end

  // Behavioural model: a run is NUM vectors; the verdict is fixed when the last one is captured.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NI; g++) begin
        m_run[g]  <= 1'b0;
        m_fin[g]  <= 1'b0;
        m_pass[g] <= 1'b0;
        m_lfsr[g] <= '0;
        m_misr[g] <= '0;
        m_cnt[g]  <= 0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        logic [15:0] nm;
        nm = poly_step(m_misr[g]) ^ {3'b000, resp[g]};
        if (m_run[g]) begin
          m_misr[g] <= nm;
          m_lfsr[g] <= poly_step(m_lfsr[g]);
          m_cnt[g]  <= m_cnt[g] + 1;
          if (m_cnt[g] + 1 == NUMS[g]) begin
            m_run[g]  <= 1'b0;
            m_fin[g]  <= 1'b1;
            m_pass[g] <= (nm == GOLDS[g]);
          end
        end else if (start_v[g]) begin
          m_run[g]  <= 1'b1;
          m_fin[g]  <= 1'b0;
          m_pass[g] <= 1'b0;
          m_lfsr[g] <= (SEEDS[g] == 16'h0000) ? 16'h0001 : SEEDS[g];
          m_misr[g] <= '0;
          m_cnt[g]  <= 0;
        end
      end
    end
  end

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %h, want %h", nm, g, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NI; g++) begin
        check("pat_o",     g, 32'(pat[g]),    32'(m_lfsr[g]));
        check("signature", g, 32'(sig[g]),    32'(m_misr[g]));
        check("pat_count", g, 32'(cnt[g]),    m_cnt[g]);
        check("busy",      g, 32'(busy_v[g]), 32'(m_run[g]));
        check("done",      g, 32'(done_v[g]), 32'(m_fin[g]));
        check("pass",      g, 32'(pass_v[g]), 32'(m_pass[g]));
      end
    end
  end

  task automatic pulse_start(input logic [NI-1:0] which);
    start_v = which;
    @(negedge clk);
    start_v = '0;
  endtask

  task automatic wait_done(input int g);
    for (int c = 0; c < 400 && !done_v[g]; c++) @(negedge clk);
    check("done_timeout", g, 32'(done_v[g]), 32'd1);
  endtask

  initial begin
    int          busy_n;
    logic [15:0] gold256;
    rst_n   = 1'b0;
    start_v = '0;
    mode    = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1};
    flip    = '{default: 13'h0000};
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pat", 0, 32'(pat[0]), 32'h0);
    check("idle_busy", 0, 32'(busy_v[0]), 32'h0);

    // Default run with zero responses; small-N instances finish alongside.
    pulse_start('1);
    busy_n = 0;
    for (int c = 0; c < 400 && !done_v[0]; c++) begin
      if (busy_v[0]) busy_n++;
      if (c == 0) begin
        check("first_pat", 0, 32'(pat[0]), 32'hACE1);
        check("zero_seed_pat", 5, 32'(pat[5]), 32'h0001);
      end
      if (c == 1) begin
        check("second_pat", 0, 32'(pat[0]), 32'h59C3);
        check("n1_done", 1, 32'(done_v[1]), 32'd1);
        check("n1_sig", 1, 32'(sig[1]), 32'h0001);
        check("n1_count", 1, 32'(cnt[1]), 32'd1);
        check("n1_pass", 1, 32'(pass_v[1]), 32'd0);
      end
      if (c == 2) begin
        check("n2_sig", 2, 32'(sig[2]), 32'h0003);
        check("n2_pass", 2, 32'(pass_v[2]), 32'd0);
        check("n2_gold_pass", 3, 32'(pass_v[3]), 32'd1);
      end
      if (c == 10) start_v[0] = 1'b1;
      if (c == 20) start_v[0] = 1'b0;
      @(negedge clk);
    end
    check("busy_cycles", 0, busy_n, 32'd256);
    check("zero_sig", 0, 32'(sig[0]), 32'h0);
    check("zero_pass", 0, 32'(pass_v[0]), 32'd1);
    check("net_gold_pass", 4, 32'(pass_v[4]), 32'd1);

    // Random responses; instance 1 restarts repeatedly from DONE; one flipped bit on instance 4.
    mode[0] = 2'd2;
    start_v = '1;
    @(negedge clk);
    start_v = 6'b000010;
    for (int c = 0; c < 400 && !done_v[0]; c++) begin
      if (c == 30) flip[4] = 13'd1 << $urandom_range(0, 12);
      if (c == 31) flip[4] = '0;
      @(negedge clk);
    end
    check("random_done", 0, 32'(done_v[0]), 32'd1);
    check("fault_pass", 4, 32'(pass_v[4]), 32'd0);
    start_v = '0;
    repeat (3) @(negedge clk);

    // Asynchronous abort at RUN cycle 100.
    pulse_start(6'b000001);
    repeat (99) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pat", 0, 32'(pat[0]), 32'h0);
    check("abort_sig", 0, 32'(sig[0]), 32'h0);
    check("abort_count", 0, 32'(cnt[0]), 32'h0);
    check("abort_busy", 0, 32'(busy_v[0]), 32'h0);
    check("abort_done", 0, 32'(done_v[0]), 32'h0);
    check("abort_pass", 0, 32'(pass_v[0]), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_idle", 0, 32'(busy_v[0] | done_v[0]), 32'h0);

    // Netlist responses, run twice back to back from DONE.
    mode[0] = 2'd3;
    gold256 = golden(256, 16'hACE1);
    for (int r = 0; r < 2; r++) begin
      pulse_start(6'b000001);
      wait_done(0);
      check("restart_sig", r, 32'(sig[0]), 32'(gold256));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
